// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 4-bit LCD sequencer.
package lcd_pkg;

  localparam int unsigned WAIT_CNT_W = 20;
  localparam int unsigned INIT_STEPS = 8;

  typedef enum logic [2:0] {
    PWRUP_WAIT,
    INIT,
    NIB_HI,
    NIB_LO,
    WAIT,
    IDLE
  } lcd_state_e;

  typedef enum logic [1:0] {
    W_INIT1,
    W_INIT2,
    W_CMD,
    W_CLR
  } wait_sel_e;

  typedef struct packed {
    logic       isNibble;
    logic       rs;
    logic [7:0] data;
    wait_sel_e  waitSel;
  } init_entry_t;

  // Clear display (0x01) and return home (0x02/0x03) need the long settle time.
  function automatic logic is_clear_home(input logic rs, input logic [7:0] data);
    return !rs && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
  endfunction

  // Power-on init program: three 0x3 wake nibbles, 0x2 to enter 4-bit mode,
  // then function set, display on, clear, entry mode as full bytes.
  function automatic init_entry_t init_rom(input logic [2:0] idx);
    init_entry_t entry;
    case (idx)
      3'd0:    entry = '{1'b1, 1'b0, 8'h03, W_INIT1};
      3'd1:    entry = '{1'b1, 1'b0, 8'h03, W_INIT2};
      3'd2:    entry = '{1'b1, 1'b0, 8'h03, W_INIT2};
      3'd3:    entry = '{1'b1, 1'b0, 8'h02, W_CMD};
      3'd4:    entry = '{1'b0, 1'b0, 8'h28, W_CMD};
      3'd5:    entry = '{1'b0, 1'b0, 8'h0C, W_CMD};
      3'd6:    entry = '{1'b0, 1'b0, 8'h01, W_CLR};
      default: entry = '{1'b0, 1'b0, 8'h06, W_CMD};
    endcase
    return entry;
  endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Drives one timed 4-bit transfer: setup with E low, E high pulse, hold gap.
module lcd_nibble_tx #(
  parameter int unsigned E_SETUP_CYC    = 2,
  parameter int unsigned E_HIGH_CYC     = 14,
  parameter int unsigned NIBBLE_GAP_CYC = 27
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rs,
  input  logic [3:0] nib,
  output logic       busy,
  output logic       done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [3:0] lcd_db
);

  localparam int unsigned NIB_CYC = E_SETUP_CYC + E_HIGH_CYC + NIBBLE_GAP_CYC;
  localparam logic [15:0] NIB_LAST = 16'(NIB_CYC - 1);
  localparam logic [15:0] E_ON     = 16'(E_SETUP_CYC);
  localparam logic [15:0] E_OFF    = 16'(E_SETUP_CYC + E_HIGH_CYC);

  logic        busy_q, busy_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rs_q, rs_d;
  logic [3:0]  db_q, db_d;
  logic        e_q, e_d;

  // Next-state: a start (even on the last cycle of a nibble) reloads bus and counter.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rs_d   = rs_q;
    db_d   = db_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rs_d   = rs;
      db_d   = nib;
    end else if (busy_q) begin
      if (cnt_q == NIB_LAST) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
    e_d = busy_d && (cnt_d >= E_ON) && (cnt_d < E_OFF);
  end

  // Registered pins so E never glitches; rs/db keep their value once idle.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rs_q   <= 1'b0;
      db_q   <= '0;
      e_q    <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rs_q   <= rs_d;
      db_q   <= db_d;
      e_q    <= e_d;
    end
  end

  assign busy   = busy_q;
  assign done   = busy_q && (cnt_q == NIB_LAST);
  assign lcd_e  = e_q;
  assign lcd_rs = rs_q;
  assign lcd_db = db_q;

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 4-bit sequencer: power-on init, then byte writes via valid/ready.
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned PWRUP_CYC      = 540000,
  parameter int unsigned INIT_WAIT1_CYC = 121500,
  parameter int unsigned INIT_WAIT2_CYC = 2700,
  parameter int unsigned CMD_WAIT_CYC   = 1350,
  parameter int unsigned CLR_WAIT_CYC   = 54000,
  parameter int unsigned E_SETUP_CYC    = 2,
  parameter int unsigned E_HIGH_CYC     = 14,
  parameter int unsigned NIBBLE_GAP_CYC = 27
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       init_done,
  output logic       lcd_e,
  output logic       lcd_rw,
  output logic       lcd_rs,
  output logic [3:0] lcd_db
);

  localparam logic [WAIT_CNT_W-1:0] PWRUP_LAST = WAIT_CNT_W'(PWRUP_CYC - 1);
  localparam logic [WAIT_CNT_W-1:0] INIT1_LAST = WAIT_CNT_W'(INIT_WAIT1_CYC - 1);
  localparam logic [WAIT_CNT_W-1:0] INIT2_LAST = WAIT_CNT_W'(INIT_WAIT2_CYC - 1);
  localparam logic [WAIT_CNT_W-1:0] CMD_LAST   = WAIT_CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [WAIT_CNT_W-1:0] CLR_LAST   = WAIT_CNT_W'(CLR_WAIT_CYC - 1);

  lcd_state_e            state_q, state_d;
  logic [WAIT_CNT_W-1:0] waitCnt_q, waitCnt_d;
  logic [2:0]            step_q, step_d;
  wait_sel_e             waitSel_q, waitSel_d;
  logic                  byteRs_q, byteRs_d;
  logic [3:0]            byteLo_q, byteLo_d;
  logic                  initDone_q, initDone_d;

  logic                  txStart, txRs, txBusy, txDone;
  logic [3:0]            txNib;
  logic                  doLaunch;
  logic [2:0]            launchIdx;
  init_entry_t           romEntry;
  logic [WAIT_CNT_W-1:0] waitLast;

  lcd_nibble_tx #(
    .E_SETUP_CYC   (E_SETUP_CYC),
    .E_HIGH_CYC    (E_HIGH_CYC),
    .NIBBLE_GAP_CYC(NIBBLE_GAP_CYC)
  ) u_nibble_tx (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .start  (txStart),
    .rs     (txRs),
    .nib    (txNib),
    .busy   (txBusy),
    .done   (txDone),
    .lcd_e  (lcd_e),
    .lcd_rs (lcd_rs),
    .lcd_db (lcd_db)
  );

  // Select the init step to launch and the length of the current wait.
  always_comb begin
    launchIdx = (state_q == PWRUP_WAIT) ? 3'd0 : (step_q + 3'd1);
    romEntry  = init_rom(launchIdx);
    waitLast  = CMD_LAST;
    case (waitSel_q)
      W_INIT1: waitLast = INIT1_LAST;
      W_INIT2: waitLast = INIT2_LAST;
      W_CMD:   waitLast = CMD_LAST;
      W_CLR:   waitLast = CLR_LAST;
      default: waitLast = CMD_LAST;
    endcase
  end

  // Main sequencer: a new transfer is launched on the last cycle of the
  // preceding wait so the nibble engine starts with no dead cycle.
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    step_d     = step_q;
    waitSel_d  = waitSel_q;
    byteRs_d   = byteRs_q;
    byteLo_d   = byteLo_q;
    initDone_d = initDone_q;
    txStart    = 1'b0;
    txRs       = byteRs_q;
    txNib      = byteLo_q;
    doLaunch   = 1'b0;
    case (state_q)
      PWRUP_WAIT: begin
        if (waitCnt_q == PWRUP_LAST) begin
          waitCnt_d = '0;
          doLaunch  = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      INIT, NIB_LO: begin
        if (txDone) begin
          state_d   = WAIT;
          waitCnt_d = '0;
        end
      end
      NIB_HI: begin
        if (txDone) begin
          txStart = 1'b1;
          state_d = NIB_LO;
        end
      end
      WAIT: begin
        if (waitCnt_q == waitLast) begin
          waitCnt_d = '0;
          if (initDone_q || (step_q == 3'(INIT_STEPS - 1))) begin
            state_d    = IDLE;
            initDone_d = 1'b1;
          end else begin
            step_d   = step_q + 3'd1;
            doLaunch = 1'b1;
          end
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (cmd_valid) begin
          txStart   = 1'b1;
          txRs      = cmd_rs;
          txNib     = cmd_data[7:4];
          byteRs_d  = cmd_rs;
          byteLo_d  = cmd_data[3:0];
          waitSel_d = is_clear_home(cmd_rs, cmd_data) ? W_CLR : W_CMD;
          state_d   = NIB_HI;
        end
      end
      default: state_d = PWRUP_WAIT;
    endcase
    if (doLaunch) begin
      txStart   = 1'b1;
      txRs      = romEntry.rs;
      byteRs_d  = romEntry.rs;
      byteLo_d  = romEntry.data[3:0];
      waitSel_d = romEntry.waitSel;
      if (romEntry.isNibble) begin
        txNib   = romEntry.data[3:0];
        state_d = INIT;
      end else begin
        txNib   = romEntry.data[7:4];
        state_d = NIB_HI;
      end
    end
  end

  // State and wait-counter registers; reset restarts the full init sequence.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PWRUP_WAIT;
      waitCnt_q  <= '0;
      step_q     <= '0;
      waitSel_q  <= W_INIT1;
      byteRs_q   <= 1'b0;
      byteLo_q   <= '0;
      initDone_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      step_q     <= step_d;
      waitSel_q  <= waitSel_d;
      byteRs_q   <= byteRs_d;
      byteLo_q   <= byteLo_d;
      initDone_q <= initDone_d;
    end
  end

  // The nibble engine must always be quiet whenever the sequencer is idle.
  assert property (@(posedge sys_clk) disable iff (!rst_n) (state_q == IDLE) |-> !txBusy);

  assign cmd_ready = (state_q == IDLE);
  assign init_done = initDone_q;
  assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed bench for lcd_hd44780_ctrl using shortened timing parameters.
module tb_lcd_hd44780_ctrl;

  localparam int unsigned PWRUP = 100;
  localparam int unsigned W1    = 50;
  localparam int unsigned W2    = 20;
  localparam int unsigned WC    = 10;
  localparam int unsigned WCLR  = 40;
  localparam int unsigned ES    = 2;
  localparam int unsigned EH    = 4;
  localparam int unsigned GAP   = 3;
  localparam int unsigned NIB   = ES + EH + GAP;

  if ((PWRUP >= 2**20) || (W1 >= 2**20) || (W2 >= 2**20) || (WC >= 2**20) ||
      (WCLR >= 2**20) || (ES >= 2**20) || (EH >= 2**20) || (GAP >= 2**20)) begin : g_param_range
    $error("[TB] timing parameter does not fit the 20-bit wait counter");
  end

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_rs    = 1'b0;
  logic [7:0] cmd_data  = 8'h00;
  logic       cmd_ready, init_done, lcd_e, lcd_rw, lcd_rs;
  logic [3:0] lcd_db;

  int testsRun    = 0;
  int testsFailed = 0;

  lcd_hd44780_ctrl #(
    .PWRUP_CYC     (PWRUP),
    .INIT_WAIT1_CYC(W1),
    .INIT_WAIT2_CYC(W2),
    .CMD_WAIT_CYC  (WC),
    .CLR_WAIT_CYC  (WCLR),
    .E_SETUP_CYC   (ES),
    .E_HIGH_CYC    (EH),
    .NIBBLE_GAP_CYC(GAP)
  ) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_rs   (cmd_rs),
    .cmd_data (cmd_data),
    .cmd_ready(cmd_ready),
    .init_done(init_done),
    .lcd_e    (lcd_e),
    .lcd_rw   (lcd_rw),
    .lcd_rs   (lcd_rs),
    .lcd_db   (lcd_db)
  );

  // 100 MHz-style bench clock; only cycle counts matter.
  always #5 sys_clk = ~sys_clk;

  // Pulse monitor: records db/rs at every E fall plus the high width of each pulse.
  logic       ePrev   = 1'b0;
  int         highLen = 0;
  int         rwErrors = 0;
  logic [3:0] pulseDb[$];
  logic       pulseRs[$];
  int         pulseLen[$];

  always @(negedge sys_clk) begin
    if (lcd_rw !== 1'b0) rwErrors++;
    if (lcd_e === 1'b1) highLen++;
    if (ePrev && (lcd_e !== 1'b1)) begin
      pulseDb.push_back(lcd_db);
      pulseRs.push_back(lcd_rs);
      pulseLen.push_back(highLen);
      highLen = 0;
    end
    ePrev = (lcd_e === 1'b1);
  end

  // Hard stop in case something blocks unexpectedly.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic doReset();
    rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    pulseDb.delete();
    pulseRs.delete();
    pulseLen.delete();
    highLen = 0;
    rst_n = 1'b1;
  endtask

  // Runs from reset release until cmd_ready first rises, sampling each negedge.
  task automatic runInit(output int firstRise, output int firstReady,
                         output logic doneBefore, output logic doneAt);
    firstRise  = -1;
    firstReady = -1;
    doneBefore = 1'bx;
    doneAt     = 1'bx;
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      @(negedge sys_clk);
      if ((firstRise < 0) && (lcd_e === 1'b1)) firstRise = cyc;
      if (cmd_ready === 1'b1) begin
        firstReady = cyc;
        doneAt     = init_done;
        break;
      end
      doneBefore = init_done;
    end
  endtask

  task automatic test_reset();
    #1;
    testsRun++; if (lcd_e !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_e: got %b expected 0", lcd_e); end
    testsRun++; if (lcd_rw !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rw: got %b expected 0", lcd_rw); end
    testsRun++; if (lcd_rs !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rs: got %b expected 0", lcd_rs); end
    testsRun++; if (lcd_db !== 4'h0) begin testsFailed++; $display("[TB] FAIL reset_db: got %h expected 0", lcd_db); end
    testsRun++; if (cmd_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ready: got %b expected 0", cmd_ready); end
    testsRun++; if (init_done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_init_done: got %b expected 0", init_done); end
  endtask

  task automatic test_init();
    int   fr, rdy;
    logic db4, da;
    logic [3:0] expDb [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};
    int   rsHigh;
    cmd_valid = 1'b0;
    doReset();
    runInit(fr, rdy, db4, da);
    testsRun++; if (fr != 102) begin testsFailed++; $display("[TB] FAIL init_first_e_rise: got cycle %0d expected 102", fr); end
    testsRun++; if (rdy != 378) begin testsFailed++; $display("[TB] FAIL init_ready_cycle: got cycle %0d expected 378", rdy); end
    testsRun++; if (db4 !== 1'b0) begin testsFailed++; $display("[TB] FAIL init_done_early: got %b expected 0", db4); end
    testsRun++; if (da !== 1'b1) begin testsFailed++; $display("[TB] FAIL init_done_at_idle: got %b expected 1", da); end
    testsRun++; if (pulseDb.size() != 12) begin testsFailed++; $display("[TB] FAIL init_pulse_count: got %0d expected 12", pulseDb.size()); end
    for (int i = 0; i < 12; i++) begin
      testsRun++;
      if (i >= pulseDb.size()) begin
        testsFailed++; $display("[TB] FAIL init_db_%0d: got no pulse expected %h", i, expDb[i]);
      end else if (pulseDb[i] !== expDb[i]) begin
        testsFailed++; $display("[TB] FAIL init_db_%0d: got %h expected %h", i, pulseDb[i], expDb[i]);
      end
    end
    rsHigh = 0;
    foreach (pulseRs[i]) if (pulseRs[i] !== 1'b0) rsHigh++;
    testsRun++; if (rsHigh != 0) begin testsFailed++; $display("[TB] FAIL init_rs: got %0d pulses with rs=1 expected 0", rsHigh); end
    testsRun++; if (rwErrors != 0) begin testsFailed++; $display("[TB] FAIL rw_low: got %0d samples with rw!=0 expected 0", rwErrors); end
  endtask

  // One byte write from idle; checks every cycle of both nibbles and the wait.
  task automatic test_byte(input string name, input logic rs, input logic [7:0] data, input int expLatency);
    int latency = -1;
    int eBad = 0, dbBad = 0, rsBad = 0, lenBad = 0;
    int j;
    logic expE;
    logic [3:0] expNib;
    testsRun++; if (cmd_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL %s_ready_before: got %b expected 1", name, cmd_ready); end
    pulseDb.delete(); pulseRs.delete(); pulseLen.delete();
    cmd_valid = 1'b1; cmd_rs = rs; cmd_data = data;
    for (int k = 1; k <= 200; k++) begin
      @(negedge sys_clk);
      if (k == 1) cmd_valid = 1'b0;
      j      = (k - 1) % NIB;
      expE   = (k <= 2 * NIB) && (j >= ES) && (j < ES + EH);
      expNib = (k <= NIB) ? data[7:4] : data[3:0];
      if (lcd_e !== expE) eBad++;
      if (lcd_db !== expNib) dbBad++;
      if (lcd_rs !== rs) rsBad++;
      if (cmd_ready === 1'b1) begin latency = k - 1; break; end
    end
    foreach (pulseLen[i]) if (pulseLen[i] != EH) lenBad++;
    testsRun++; if (latency != expLatency) begin testsFailed++; $display("[TB] FAIL %s_latency: got %0d expected %0d", name, latency, expLatency); end
    testsRun++; if (pulseDb.size() != 2) begin testsFailed++; $display("[TB] FAIL %s_pulses: got %0d expected 2", name, pulseDb.size()); end
    testsRun++; if ((pulseDb.size() < 2) || (pulseDb[0] !== data[7:4]) || (pulseDb[1] !== data[3:0])) begin
      testsFailed++; $display("[TB] FAIL %s_nibbles: got %0d pulses expected %h then %h", name, pulseDb.size(), data[7:4], data[3:0]);
    end
    testsRun++; if (eBad != 0) begin testsFailed++; $display("[TB] FAIL %s_e_shape: got %0d bad cycles expected 0", name, eBad); end
    testsRun++; if (dbBad != 0) begin testsFailed++; $display("[TB] FAIL %s_db_stable: got %0d bad cycles expected 0", name, dbBad); end
    testsRun++; if (rsBad != 0) begin testsFailed++; $display("[TB] FAIL %s_rs_stable: got %0d bad cycles expected 0", name, rsBad); end
    testsRun++; if (lenBad != 0) begin testsFailed++; $display("[TB] FAIL %s_e_width: got %0d bad pulses expected 0", name, lenBad); end
  endtask

  task automatic test_hold_during_init();
    int   fr, rdy, latency;
    logic db4, da;
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h55;
    doReset();
    runInit(fr, rdy, db4, da);
    testsRun++; if (fr != 102) begin testsFailed++; $display("[TB] FAIL hold_first_e_rise: got cycle %0d expected 102", fr); end
    testsRun++; if (rdy != 378) begin testsFailed++; $display("[TB] FAIL hold_ready_cycle: got cycle %0d expected 378", rdy); end
    testsRun++; if (pulseDb.size() != 12) begin testsFailed++; $display("[TB] FAIL hold_init_pulses: got %0d expected 12", pulseDb.size()); end
    pulseDb.delete(); pulseRs.delete(); pulseLen.delete();
    @(negedge sys_clk);
    testsRun++; if (cmd_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL hold_accept: got ready %b expected 0", cmd_ready); end
    cmd_valid = 1'b0;
    latency = -1;
    for (int k = 2; k <= 200; k++) begin
      @(negedge sys_clk);
      if (cmd_ready === 1'b1) begin latency = k - 1; break; end
    end
    testsRun++; if (latency != 28) begin testsFailed++; $display("[TB] FAIL hold_latency: got %0d expected 28", latency); end
    testsRun++; if ((pulseDb.size() != 2) || (pulseDb[0] !== 4'h5) || (pulseDb[1] !== 4'h5)) begin
      testsFailed++; $display("[TB] FAIL hold_single_transfer: got %0d pulses expected 2 pulses of 5", pulseDb.size());
    end
  endtask

  task automatic test_reset_mid();
    int   fr, rdy;
    logic db4, da;
    logic sawE = 1'b0;
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h28;
    for (int k = 1; k <= 50; k++) begin
      @(negedge sys_clk);
      cmd_valid = 1'b0;
      if (lcd_e === 1'b1) begin sawE = 1'b1; break; end
    end
    testsRun++; if (sawE !== 1'b1) begin testsFailed++; $display("[TB] FAIL mid_e_seen: got %b expected 1", sawE); end
    #1 rst_n = 1'b0;
    #1;
    testsRun++; if (lcd_e !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_e: got %b expected 0", lcd_e); end
    testsRun++; if (lcd_rs !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_rs: got %b expected 0", lcd_rs); end
    testsRun++; if (lcd_db !== 4'h0) begin testsFailed++; $display("[TB] FAIL mid_db: got %h expected 0", lcd_db); end
    testsRun++; if (cmd_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_ready: got %b expected 0", cmd_ready); end
    doReset();
    runInit(fr, rdy, db4, da);
    testsRun++; if (fr != 102) begin testsFailed++; $display("[TB] FAIL mid_restart_e_rise: got cycle %0d expected 102", fr); end
    testsRun++; if (rdy != 378) begin testsFailed++; $display("[TB] FAIL mid_restart_ready: got cycle %0d expected 378", rdy); end
    testsRun++; if (pulseDb.size() != 12) begin testsFailed++; $display("[TB] FAIL mid_restart_pulses: got %0d expected 12", pulseDb.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [3] = '{8'h30, 8'h31, 8'h32};
    logic [3:0] expDb [6] = '{4'h3, 4'h0, 4'h3, 4'h1, 4'h3, 4'h2};
    int   gaps [3] = '{-1, -1, -1};
    int   accepted = 1;
    int   lowRun = 0;
    int   rsLow = 0;
    logic just = 1'b1;
    logic finished = 1'b0;
    pulseDb.delete(); pulseRs.delete(); pulseLen.delete();
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = vals[0];
    for (int k = 0; (k < 300) && !finished; k++) begin
      @(negedge sys_clk);
      if (just) begin
        just = 1'b0;
        if (accepted < 3) cmd_data = vals[accepted];
        else cmd_valid = 1'b0;
      end
      if (cmd_ready === 1'b1) begin
        gaps[accepted - 1] = lowRun;
        lowRun = 0;
        if (accepted < 3) begin accepted++; just = 1'b1; end
        else finished = 1'b1;
      end else begin
        lowRun++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      testsRun++; if (gaps[i] != 28) begin testsFailed++; $display("[TB] FAIL b2b_gap_%0d: got %0d expected 28", i, gaps[i]); end
    end
    testsRun++; if (pulseDb.size() != 6) begin testsFailed++; $display("[TB] FAIL b2b_pulses: got %0d expected 6", pulseDb.size()); end
    for (int i = 0; i < 6; i++) begin
      testsRun++;
      if ((i >= pulseDb.size()) || (pulseDb[i] !== expDb[i])) begin
        testsFailed++; $display("[TB] FAIL b2b_db_%0d: got %h expected %h", i, (i < pulseDb.size()) ? pulseDb[i] : 4'hx, expDb[i]);
      end
    end
    foreach (pulseRs[i]) if (pulseRs[i] !== 1'b1) rsLow++;
    testsRun++; if (rsLow != 0) begin testsFailed++; $display("[TB] FAIL b2b_rs: got %0d pulses with rs=0 expected 0", rsLow); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_byte("data_41", 1'b1, 8'h41, 28);
    test_byte("clear_cmd", 1'b0, 8'h01, 58);
    test_byte("data_01", 1'b1, 8'h01, 28);
    test_reset_mid();
    test_back_to_back();
    test_hold_during_init();
    testsRun++; if (rwErrors != 0) begin testsFailed++; $display("[TB] FAIL rw_low_final: got %0d samples with rw!=0 expected 0", rwErrors); end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
